port_echo: RTL
==============

PORT_ECHO -- requirements
Module: port_echo

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of every data word.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (need not be a power of two).
REQ-003 SHALL have parameter FIFO_D, default 4, read-response FIFO depth (>=2).
REQ-004 SHALL define local AW = max(1, $clog2(DEPTH)) and CW = $clog2(FIFO_D+1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  request accepted when high with in_valid.
REQ-009 in_op  input  1  0=READ, 1=WRITE (package enum).
REQ-010 in_addr  input  AW  entry index.
REQ-011 in_data  input  DATA_W  write data.
REQ-012 out_valid  output  1  read response valid.
REQ-013 out_ready  input  1  response consumed when high with out_valid.
REQ-014 out_data  output  DATA_W  read response data.
REQ-015 mem_view  output  DATA_W x unpacked [0:DEPTH-1]  live storage contents.
REQ-016 bidir_oe  input  1  drive enable for bidir_port.
REQ-017 bidir_port  inout  DATA_W  driven with last_rd when bidir_oe=1, else high-Z.
REQ-018 bidir_sample  output  DATA_W  bidir_port value registered each cycle bidir_oe=0.
REQ-019 err  output  1  sticky: a request with in_addr >= DEPTH was accepted.
REQ-020 txn_cnt  output  32  accepted-request count, wraps at 2^32.
REQ-021 fifo_cnt  output  CW  current response FIFO occupancy.

Function
REQ-022 Handshake: accept = in_valid & in_ready; in_ready = (fifo_cnt < FIFO_D) for both ops.
REQ-023 WRITE with in_addr < DEPTH: mem[in_addr] <= in_data at the accepting edge; no response.
REQ-024 READ with in_addr < DEPTH: push mem[in_addr] into the FIFO at the accepting edge; update last_rd to the same value.
REQ-025 READ after WRITE to same address on the next cycle SHALL return the new data.
REQ-026 Out-of-range (in_addr >= DEPTH): WRITE dropped; READ pushes all-zero data; err set in both cases.
REQ-027 Latency: READ accepted at edge N with FIFO empty -> out_valid=1 and out_data valid after edge N (combinational from FIFO head, no extra register).
REQ-028 out_valid = (fifo_cnt != 0); pop on out_valid & out_ready.
REQ-029 Simultaneous push and pop when full: in_ready=0, so no push; pop proceeds; in_ready=1 the following cycle.
REQ-030 Simultaneous push and pop when non-full and non-empty: fifo_cnt unchanged; order preserved.
REQ-031 FIFO pointers wrap modulo FIFO_D; ordering strictly first-in first-out.
REQ-032 txn_cnt increments by 1 on every accept regardless of op or range.
REQ-033 in_valid held with in_ready=0 SHALL NOT alter state; request is accepted when in_ready rises.

Reset
REQ-034 rst_n low asynchronously sets: all mem entries 0, FIFO empty (fifo_cnt=0, out_valid=0), out_data=0, last_rd=0, bidir_sample=0, err=0, txn_cnt=0.
REQ-035 Reset mid-operation discards all queued responses; in_ready=1 on the first edge after release.
REQ-036 bidir_port SHALL be high-Z during reset regardless of bidir_oe.

Structure
REQ-037 Package port_echo_pkg SHALL hold the op enum (OP_READ=0, OP_WRITE=1) and default parameter constants.
REQ-038 Response FIFO SHALL be sub-module port_echo_fifo (params DATA_W, FIFO_D; push/pop/full/empty/count).

Verification
REQ-039 DATA_W=64,DEPTH=16: WRITE addr3=0xDEADBEEF, then READ addr3 -> out_data=0xDEADBEEF one edge after READ accept; mem_view[3]=0xDEADBEEF.
REQ-040 out_ready=0, issue 5 READs with FIFO_D=4 -> 4 accepted, in_ready=0, fifo_cnt=4; raise out_ready -> 4 responses in order, then 5th accepted.
REQ-041 DEPTH=10: WRITE addr12 -> mem unchanged, err=1; READ addr12 -> out_data=0, err stays 1.
REQ-042 bidir_oe=1 after READ of 0xA5 -> bidir_port=0xA5; bidir_oe=0, drive 0x3C externally -> bidir_sample=0x3C next edge.
REQ-043 With 3 responses queued and txn_cnt=7, pulse rst_n low mid-cycle -> out_valid=0, fifo_cnt=0, txn_cnt=0, mem_view all 0 immediately.

Source files
------------

// File: rtl/port_echo_pkg.sv
// Shared op encoding and default sizing for the port_echo storage/echo block.
package port_echo_pkg;
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 16;
  localparam int FIFO_D_DEF = 4;
endpackage

// File: rtl/port_echo_fifo.sv
// Read-response FIFO; head is presented combinationally so a response is visible right after its push edge.
module port_echo_fifo #(
  parameter  int DATA_W = 64,
  parameter  int FIFO_D = 4,
  localparam int PW     = $clog2(FIFO_D),
  localparam int CW     = $clog2(FIFO_D + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] buf_q [0:FIFO_D-1];
  logic [DATA_W-1:0] buf_d [0:FIFO_D-1];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(FIFO_D));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = empty ? '0 : buf_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap explicitly so FIFO_D need not be a power of two.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      buf_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_D - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop)
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_D - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_D; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/port_echo.sv
// Small addressable store: writes update an entry, reads echo the entry through a response FIFO and a bidir port.
module port_echo
  import port_echo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int FIFO_D = FIFO_D_DEF,
  localparam int AW     = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int CW     = $clog2(FIFO_D + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_e               in_op,
  input  logic [AW-1:0]     in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] mem_view [0:DEPTH-1],
  input  logic              bidir_oe,
  inout  wire  [DATA_W-1:0] bidir_port,
  output logic [DATA_W-1:0] bidir_sample,
  output logic              err,
  output logic [31:0]       txn_cnt,
  output logic [CW-1:0]     fifo_cnt
);
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] mem_d [0:DEPTH-1];
  logic [DATA_W-1:0] last_rd_q, last_rd_d;
  logic [DATA_W-1:0] bidir_sample_q, bidir_sample_d;
  logic              err_q, err_d;
  logic [31:0]       txn_cnt_q, txn_cnt_d;
  logic              accept, in_range, push, pop, full, empty;
  logic [DATA_W-1:0] rd_data;

  assign in_range = (32'(in_addr) < 32'(DEPTH));
  assign rd_data  = in_range ? mem_q[in_addr] : '0;
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & (in_op == OP_READ);
  assign pop      = out_valid & out_ready;

  always_comb begin
    mem_d          = mem_q;
    last_rd_d      = last_rd_q;
    err_d          = err_q;
    txn_cnt_d      = txn_cnt_q;
    bidir_sample_d = bidir_oe ? bidir_sample_q : bidir_port;
    if (accept) begin
      txn_cnt_d = txn_cnt_q + 32'd1;
      if (!in_range)              err_d = 1'b1;
      else if (in_op == OP_WRITE) mem_d[in_addr] = in_data;
      if (in_op == OP_READ)       last_rd_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_rd_q      <= '0;
      bidir_sample_q <= '0;
      err_q          <= 1'b0;
      txn_cnt_q      <= '0;
    end else begin
      mem_q          <= mem_d;
      last_rd_q      <= last_rd_d;
      bidir_sample_q <= bidir_sample_d;
      err_q          <= err_d;
      txn_cnt_q      <= txn_cnt_d;
    end
  end

  port_echo_fifo #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt),
    .head      (out_data)
  );

  // The port floats while in reset even if bidir_oe is asserted.
  assign bidir_port   = (rst_n & bidir_oe) ? last_rd_q : {DATA_W{1'bz}};
  assign out_valid    = ~empty;
  assign mem_view     = mem_q;
  assign bidir_sample = bidir_sample_q;
  assign err          = err_q;
  assign txn_cnt      = txn_cnt_q;
endmodule
